// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction fetch/decode front end:
// widths, opcode and state encodings, field positions, offset sign extension.
package isa_pkg;

  localparam int AW = 9;
  localparam int IW = 20;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 15;
  localparam int FA_HI  = 14;
  localparam int FA_LO  = 10;
  localparam int FB_HI  = 9;
  localparam int FB_LO  = 5;
  localparam int FC_HI  = 4;
  localparam int FC_LO  = 0;

  typedef enum logic [4:0] {
    OP_BE   = 5'd7,
    OP_BL   = 5'd8,
    OP_BG   = 5'd9,
    OP_BA   = 5'd10,
    OP_DONE = 5'b01110
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Branch offsets are 5-bit two's complement, applied modulo 2^AW.
  function automatic logic [AW-1:0] sext_fc(input logic [4:0] fc);
    return {{(AW-5){fc[4]}}, fc};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision and target computation for the held instruction.
module branch_resolve
  import isa_pkg::*;
(
  input  logic [4:0]    opcode,
  input  logic          flag_eq,
  input  logic          flag_lt,
  input  logic          flag_gt,
  input  logic [AW-1:0] ir_pc,
  input  logic [4:0]    fc,
  output logic          taken,
  output logic [AW-1:0] target
);

  assign target = ir_pc + sext_fc(fc);

  // Condition select per branch opcode; everything else falls through.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BE:   taken = flag_eq;
      OP_BL:   taken = flag_lt;
      OP_BG:   taken = flag_gt;
      OP_BA:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch / IR stage with one-bubble taken branches and a halt opcode.
// Optional perf counters (retired, bubbles) are enabled by defining IMEM_PERF_EN.
module imem_fetch
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          stall,
  input  logic          flag_eq,
  input  logic          flag_lt,
  input  logic          flag_gt,
  output logic [AW-1:0] iptr,
  input  logic [IW-1:0] inst,
  output logic          ir_valid,
  output logic [4:0]    opcode,
  output logic [4:0]    fa,
  output logic [4:0]    fb,
  output logic [4:0]    fc,
  output logic [AW-1:0] ir_pc,
`ifdef IMEM_PERF_EN
  output logic [15:0]   retired,
  output logic [15:0]   bubbles,
`endif
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic          done_q, done_d;
  logic          br_taken_s;
  logic [AW-1:0] br_target_s;

  assign iptr     = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir_pc    = ir_pc_q;
  assign done     = done_q;
  assign opcode   = ir_q[OPC_HI:OPC_LO];
  assign fa       = ir_q[FA_HI:FA_LO];
  assign fb       = ir_q[FB_HI:FB_LO];
  assign fc       = ir_q[FC_HI:FC_LO];

  branch_resolve u_branch_resolve (
    .opcode  (opcode),
    .flag_eq (flag_eq),
    .flag_lt (flag_lt),
    .flag_gt (flag_gt),
    .ir_pc   (ir_pc_q),
    .fc      (fc),
    .taken   (br_taken_s),
    .target  (br_target_s)
  );

  // Next-state: start beats stall; stall freezes everything including resolution.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    done_d     = done_q;
    if (start) begin
      state_d    = ST_RUN;
      pc_d       = start_addr;
      ir_valid_d = 1'b0;
      done_d     = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ir_valid_q && (opcode == OP_DONE)) begin
            ir_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_HALT;
          end else if (ir_valid_q && br_taken_s) begin
            pc_d       = br_target_s;
            ir_valid_d = 1'b0;
          end else begin
            ir_d       = inst;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: ir_valid_d = 1'b0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= {AW{1'b0}};
      ir_q       <= {IW{1'b0}};
      ir_pc_q    <= {AW{1'b0}};
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      done_q     <= done_d;
    end
  end

`ifdef IMEM_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] bubbles_q, bubbles_d;

  assign retired = retired_q;
  assign bubbles = bubbles_q;

  // Saturating counters, cleared on start.
  always_comb begin
    retired_d = retired_q;
    bubbles_d = bubbles_q;
    if (start) begin
      retired_d = 16'h0000;
      bubbles_d = 16'h0000;
    end else if (!stall) begin
      if (ir_valid_q && (retired_q != 16'hFFFF)) begin
        retired_d = retired_q + 16'h0001;
      end else begin
        retired_d = retired_q;
      end
      if ((state_q == ST_RUN) && !ir_valid_q && (bubbles_q != 16'hFFFF)) begin
        bubbles_d = bubbles_q + 16'h0001;
      end else begin
        bubbles_d = bubbles_q;
      end
    end else begin
      retired_d = retired_q;
      bubbles_d = bubbles_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
      bubbles_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Directed self-checking bench for imem_fetch with a behavioural instruction ROM.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  start_addr = 9'd0;
  logic        stall = 1'b0;
  logic        flag_eq = 1'b0, flag_lt = 1'b0, flag_gt = 1'b0;
  logic [8:0]  iptr;
  logic [19:0] inst;
  logic        ir_valid;
  logic [4:0]  opcode, fa, fb, fc;
  logic [8:0]  ir_pc;
  logic        done;
`ifdef IMEM_PERF_EN
  logic [15:0] retired, bubbles;
`endif

  logic [19:0] rom [0:511];
  int vectors = 0;
  int miscompares = 0;

  assign inst = rom[iptr];
  always #5 clk = ~clk;

  imem_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stall(stall),
    .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_gt(flag_gt), .iptr(iptr), .inst(inst),
    .ir_valid(ir_valid), .opcode(opcode), .fa(fa), .fb(fb), .fc(fc), .ir_pc(ir_pc),
`ifdef IMEM_PERF_EN
    .retired(retired), .bubbles(bubbles),
`endif
    .done(done)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [8:0] addr);
    start = 1'b1;
    start_addr = addr;
    step();
    start = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    chk("rst_ir_valid", int'(ir_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_iptr", int'(iptr), 0);
    chk("rst_ir_pc", int'(ir_pc), 0);
    chk("rst_opcode", int'(opcode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_ir_valid", int'(ir_valid), 0);
  endtask

  task automatic test_basic();
    rom[1] = 20'h60A20;
    rom[2] = 20'h70000;
    do_start(9'd1);
    chk("basic_start_valid", int'(ir_valid), 0);
    chk("basic_start_iptr", int'(iptr), 1);
    step();
    chk("basic_valid", int'(ir_valid), 1);
    chk("basic_opcode", int'(opcode), 12);
    chk("basic_fa", int'(fa), 2);
    chk("basic_fb", int'(fb), 17);
    chk("basic_fc", int'(fc), 0);
    chk("basic_ir_pc", int'(ir_pc), 1);
    step();
    chk("basic_done_op", int'(opcode), 14);
    chk("basic_done_pre", int'(done), 0);
    step();
    chk("basic_done", int'(done), 1);
    chk("basic_done_valid", int'(ir_valid), 0);
    chk("basic_done_iptr", int'(iptr), 3);
    step();
    chk("halt_valid", int'(ir_valid), 0);
    chk("halt_iptr", int'(iptr), 3);
  endtask

  task automatic test_branch();
    rom[5] = 20'h38004;
    flag_eq = 1'b1;
    do_start(9'd5);
    step();
    chk("be_opcode", int'(opcode), 7);
    step();
    chk("be_bubble", int'(ir_valid), 0);
    chk("be_iptr", int'(iptr), 9);
    step();
    chk("be_taken_valid", int'(ir_valid), 1);
    chk("be_taken_pc", int'(ir_pc), 9);
    flag_eq = 1'b0;
    do_start(9'd5);
    step();
    step();
    chk("be_nt_valid", int'(ir_valid), 1);
    chk("be_nt_pc", int'(ir_pc), 6);
    rom[16] = 20'h47FF3;
    flag_lt = 1'b1;
    do_start(9'd16);
    step();
    chk("bl_opcode", int'(opcode), 8);
    chk("bl_fc", int'(fc), 19);
    step();
    chk("bl_bubble", int'(ir_valid), 0);
    step();
    chk("bl_taken_pc", int'(ir_pc), 3);
    chk("bl_taken_valid", int'(ir_valid), 1);
    flag_lt = 1'b0;
  endtask

  task automatic test_stall();
    do_start(9'd20);
    step();
    step();
    chk("pre_stall_pc", int'(ir_pc), 21);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_iptr", int'(iptr), 22);
      chk("stall_ir_pc", int'(ir_pc), 21);
      chk("stall_valid", int'(ir_valid), 1);
    end
    stall = 1'b0;
    step();
    chk("resume_pc0", int'(ir_pc), 22);
    step();
    chk("resume_pc1", int'(ir_pc), 23);
    stall = 1'b1;
    do_start(9'd40);
    chk("start_over_stall", int'(iptr), 40);
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    do_start(9'd510);
    step();
    chk("wrap_iptr511", int'(iptr), 511);
    step();
    chk("wrap_ir_pc511", int'(ir_pc), 511);
    chk("wrap_iptr0", int'(iptr), 0);
    step();
    chk("wrap_ir_pc0", int'(ir_pc), 0);
    rom[4] = 20'h50010;
    do_start(9'd4);
    step();
    chk("ba_opcode", int'(opcode), 10);
    step();
    chk("ba_bubble", int'(ir_valid), 0);
    chk("ba_iptr", int'(iptr), 500);
    step();
    chk("ba_ir_pc", int'(ir_pc), 500);
  endtask

  task automatic test_async_reset();
    do_start(9'd30);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(ir_valid), 0);
    chk("arst_iptr", int'(iptr), 0);
    chk("arst_ir_pc", int'(ir_pc), 0);
    chk("arst_opcode", int'(opcode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("arst_no_restart", int'(ir_valid), 0);
    chk("arst_iptr_held", int'(iptr), 0);
    rom[0] = 20'h70000;
    do_start(9'd0);
    step();
    chk("r0_opcode", int'(opcode), 14);
    chk("r0_valid", int'(ir_valid), 1);
    step();
    chk("r0_done", int'(done), 1);
    chk("r0_done_valid", int'(ir_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 20'h00000;
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
